// File: rtl/exec_unit_mc.sv
// Execute stage: forwarded operands, single-cycle ALU/shift/rotate, iterative shift-add MUL, C/Z flags.
// Single-cycle ops register 1 cycle after accept, MUL after WIDTH cycles; in_ready drops while MUL runs.
module exec_unit_mc #(
   parameter  int WIDTH = 8,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] r1,
   input  logic [WIDTH-1:0] r2,
   input  logic [WIDTH-1:0] imm,
   input  logic             b_imm_sel,
   input  logic [1:0]       a_fwd_sel,
   input  logic [1:0]       b_fwd_sel,
   input  logic [WIDTH-1:0] ex_mem_result,
   input  logic [WIDTH-1:0] mem_wb_result,
   input  logic [SHW-1:0]   shamt,
   input  logic             c_en,
   input  logic             z_en,
   input  logic             flush,
   output logic [WIDTH-1:0] result,
   output logic             out_valid,
   output logic             c_flag,
   output logic             z_flag
);

   localparam logic [3:0] OP_ADD = 4'd0,  OP_ADC = 4'd1,  OP_SUB = 4'd2,  OP_SBC = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6,  OP_PSB = 4'd7;
   localparam logic [3:0] OP_SHL = 4'd8,  OP_SHR = 4'd9,  OP_ROL = 4'd10, OP_ROR = 4'd11;
   localparam logic [3:0] OP_MUL = 4'd12;

   typedef enum logic {IDLE, MUL_RUN} state_t;

   state_t             state, state_nxt;
   logic               accept, last_iter, cin;
   logic [WIDTH-1:0]   a_op, b_fwd, b_op;
   logic [WIDTH:0]     add_w, sub_w, shl_w, shr_w;
   logic [WIDTH-1:0]   rol_res, ror_res, alu_res;
   logic               alu_c, alu_wr;
   logic [2*WIDTH-1:0] mul_a, mul_acc, mul_acc_nxt;
   logic [WIDTH-1:0]   mul_b;
   logic [SHW-1:0]     mul_cnt;
   logic               cap_c_en, cap_z_en;

   function automatic logic [WIDTH-1:0] fwd_mux(input logic [1:0] sel, input logic [WIDTH-1:0] rf,
                                                input logic [WIDTH-1:0] exm, input logic [WIDTH-1:0] mwb);
      case (sel)
         2'b01:   return exm;
         2'b10:   return mwb;
         default: return rf;
      endcase
   endfunction

   assign a_op     = fwd_mux(a_fwd_sel, r1, ex_mem_result, mem_wb_result);
   assign b_fwd    = fwd_mux(b_fwd_sel, r2, ex_mem_result, mem_wb_result);
   assign b_op     = b_imm_sel ? imm : b_fwd;
   assign in_ready = (state == IDLE);
   assign accept   = in_valid & in_ready & ~flush;

   // Carry-in is the flag as it stands at the accept edge, so back-to-back ADC/SBC chain correctly.
   assign cin   = ((op == OP_ADC) || (op == OP_SBC)) & c_flag;
   assign add_w = {1'b0, a_op} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
   assign sub_w = {1'b0, a_op} - {1'b0, b_op} - {{WIDTH{1'b0}}, cin};
   // The extra bit catches the last bit shifted out; a zero shift leaves it clear.
   assign shl_w = {1'b0, a_op} << shamt;
   assign shr_w = {a_op, 1'b0} >> shamt;

   always_comb begin
      rol_res = '0;
      ror_res = '0;
      for (int i = 0; i < WIDTH; i++) begin
         rol_res[i] = a_op[SHW'(SHW'(i) - shamt)];
         ror_res[i] = a_op[SHW'(SHW'(i) + shamt)];
      end
   end

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_wr  = 1'b1;
      case (op)
         OP_ADD, OP_ADC: {alu_c, alu_res} = add_w;
         OP_SUB, OP_SBC: {alu_c, alu_res} = sub_w;
         OP_AND:         alu_res = a_op & b_op;
         OP_OR:          alu_res = a_op | b_op;
         OP_XOR:         alu_res = a_op ^ b_op;
         OP_PSB:         alu_res = b_op;
         OP_SHL:         {alu_c, alu_res} = shl_w;
         OP_SHR:         {alu_res, alu_c} = shr_w;
         OP_ROL: begin
            alu_res = rol_res;
            alu_c   = (shamt != '0) & rol_res[0];
         end
         OP_ROR: begin
            alu_res = ror_res;
            alu_c   = (shamt != '0) & ror_res[WIDTH-1];
         end
         default:        alu_wr = 1'b0;
      endcase
   end

   assign mul_acc_nxt = mul_b[0] ? (mul_acc + mul_a) : mul_acc;
   assign last_iter   = (mul_cnt == SHW'(WIDTH - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept && (op == OP_MUL)) state_nxt = MUL_RUN;
         MUL_RUN: if (flush || last_iter)       state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         result    <= '0;
         out_valid <= 1'b0;
         c_flag    <= 1'b0;
         z_flag    <= 1'b0;
         mul_a     <= '0;
         mul_b     <= '0;
         mul_acc   <= '0;
         mul_cnt   <= '0;
         cap_c_en  <= 1'b0;
         cap_z_en  <= 1'b0;
      end else begin
         state     <= state_nxt;
         out_valid <= 1'b0;
         if (accept) begin
            cap_c_en <= c_en;
            cap_z_en <= z_en;
            if (op == OP_MUL) begin
               mul_a   <= {{WIDTH{1'b0}}, a_op};
               mul_b   <= b_op;
               mul_acc <= '0;
               mul_cnt <= '0;
            end else begin
               out_valid <= 1'b1;
               result    <= alu_res;
               if (alu_wr && c_en) c_flag <= alu_c;
               if (alu_wr && z_en) z_flag <= (alu_res == '0);
            end
         end else if ((state == MUL_RUN) && !flush) begin
            mul_acc <= mul_acc_nxt;
            mul_a   <= {mul_a[2*WIDTH-2:0], 1'b0};
            mul_b   <= {1'b0, mul_b[WIDTH-1:1]};
            mul_cnt <= mul_cnt + SHW'(1);
            // Final partial product is folded straight into the writeback.
            if (last_iter) begin
               out_valid <= 1'b1;
               result    <= mul_acc_nxt[WIDTH-1:0];
               if (cap_c_en) c_flag <= |mul_acc_nxt[2*WIDTH-1:WIDTH];
               if (cap_z_en) z_flag <= (mul_acc_nxt[WIDTH-1:0] == '0);
            end
         end
      end
   end

endmodule

// File: tb/tb_exec_unit_mc.sv
// Scoreboard bench for exec_unit_mc: stimulus queues expected results, a negedge monitor checks each out_valid.
module tb_exec_unit_mc;
   localparam int W  = 8;
   localparam int SW = 3;

   localparam logic [3:0] ADD = 4'd0, ADC = 4'd1, SUB = 4'd2, SBC = 4'd3, AND_ = 4'd4, OR_ = 4'd5;
   localparam logic [3:0] XOR_ = 4'd6, PSB = 4'd7, SHL = 4'd8, SHR = 4'd9, ROL = 4'd10, ROR = 4'd11;
   localparam logic [3:0] MUL = 4'd12, RSV = 4'd14;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, b_imm_sel, c_en, z_en, flush;
   logic [3:0]    op;
   logic [W-1:0]  r1, r2, imm, ex_mem_result, mem_wb_result, result;
   logic [1:0]    a_fwd_sel, b_fwd_sel;
   logic [SW-1:0] shamt;
   logic          out_valid, c_flag, z_flag;

   typedef struct packed {
      logic [W-1:0] res;
      logic         c;
      logic         z;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   passes = 0;

   exec_unit_mc #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .r1(r1), .r2(r2), .imm(imm), .b_imm_sel(b_imm_sel), .a_fwd_sel(a_fwd_sel),
      .b_fwd_sel(b_fwd_sel), .ex_mem_result(ex_mem_result), .mem_wb_result(mem_wb_result),
      .shamt(shamt), .c_en(c_en), .z_en(z_en), .flush(flush), .result(result),
      .out_valid(out_valid), .c_flag(c_flag), .z_flag(z_flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act === expv) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
   endtask

   // Monitor: every result pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst === 1'b0 && out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected_out_valid: got result 0x%0h, expected no output", result);
         end else begin
            mon_e = sb.pop_front();
            chk("result", {24'b0, result}, {24'b0, mon_e.res});
            chk("c_flag", {31'b0, c_flag}, {31'b0, mon_e.c});
            chk("z_flag", {31'b0, z_flag}, {31'b0, mon_e.z});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_ab(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [SW-1:0] sh, input logic ce, input logic ze);
      op = o; r1 = a; imm = b; shamt = sh; c_en = ce; z_en = ze;
      a_fwd_sel = 2'b00; b_fwd_sel = 2'b00; b_imm_sel = 1'b1;
   endtask

   task automatic push(input logic [W-1:0] res, input logic c, input logic z);
      sb.push_back('{res: res, c: c, z: z});
   endtask

   task automatic fire();
      in_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic run1(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [SW-1:0] sh, input logic ce, input logic ze,
                       input logic [W-1:0] res, input logic c, input logic z);
      set_ab(o, a, b, sh, ce, ze);
      push(res, c, z);
      fire();
   endtask

   task automatic quiet(input string name, input int cycles);
      int seen;
      seen = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk(name, seen, 0);
   endtask

   task automatic mul_check(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] res, input logic c, input logic z);
      int low, at;
      low = 0;
      at  = 0;
      run1(MUL, a, b, 0, 1'b1, 1'b1, res, c, z);
      in_valid = 1'b0;
      for (int k = 1; k <= 12 && at == 0; k++) begin
         @(negedge clk);
         if (out_valid) at = k;
         else if (!in_ready) low++;
      end
      chk("mul_done_cycle", at, 9);
      chk("mul_ready_low_cycles", low, 8);
      chk("mul_ready_at_done", {31'b0, in_ready}, 1);
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'($urandom); op = 4'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
      imm = 8'($urandom); b_imm_sel = 1'($urandom); a_fwd_sel = 2'($urandom);
      b_fwd_sel = 2'($urandom); ex_mem_result = 8'($urandom); mem_wb_result = 8'($urandom);
      shamt = 3'($urandom); c_en = 1'($urandom); z_en = 1'($urandom); flush = 1'($urandom);
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b0; flush = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_result", {24'b0, result}, 0);
      chk("reset_c", {31'b0, c_flag}, 0);
      chk("reset_z", {31'b0, z_flag}, 0);
      chk("reset_out_valid", {31'b0, out_valid}, 0);
      chk("reset_in_ready", {31'b0, in_ready}, 1);

      // Back-to-back: ADC consumes the carry written by the preceding ADD.
      run1(ADD, 8'hF0, 8'h20, 0, 1, 1, 8'h10, 1, 0);
      run1(ADC, 8'h00, 8'h00, 0, 1, 1, 8'h01, 0, 0);

      set_ab(SUB, 8'h99, 8'h11, 0, 1, 1);
      a_fwd_sel = 2'b01; ex_mem_result = 8'h33; b_fwd_sel = 2'b10;
      push(8'h22, 0, 0); fire();
      a_fwd_sel = 2'b10; mem_wb_result = 8'h11;
      push(8'h00, 0, 1); fire();
      set_ab(SUB, 8'h03, 8'h00, 0, 1, 1);
      a_fwd_sel = 2'b11; b_imm_sel = 1'b0; b_fwd_sel = 2'b01; ex_mem_result = 8'h05; r2 = 8'h77;
      push(8'hFE, 1, 0); fire();
      set_ab(PSB, 8'h00, 8'h00, 0, 1, 1);
      b_imm_sel = 1'b0; b_fwd_sel = 2'b10; mem_wb_result = 8'h44;
      push(8'h44, 0, 0); fire();

      mul_check(8'h13, 8'h0B, 8'hD1, 0, 0);
      mul_check(8'h10, 8'h10, 8'h00, 1, 1);

      // Flush a running MUL, then present an op together with flush: both must vanish.
      set_ab(MUL, 8'h02, 8'h03, 0, 1, 1);
      fire();
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      chk("flush_in_ready", {31'b0, in_ready}, 1);
      set_ab(ADD, 8'h01, 8'h01, 0, 1, 1);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0; flush = 1'b0;
      quiet("flush_no_out_valid", 10);
      chk("flush_c_held", {31'b0, c_flag}, 1);
      chk("flush_z_held", {31'b0, z_flag}, 1);
      chk("flush_result_held", {24'b0, result}, 0);

      // Reset mid-MUL after leaving a non-zero result and set flags behind.
      run1(PSB, 8'h00, 8'h5A, 0, 0, 0, 8'h5A, 1, 1);
      in_valid = 1'b0;
      @(negedge clk);
      set_ab(MUL, 8'h03, 8'h03, 0, 1, 1);
      fire();
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midmul_rst_result", {24'b0, result}, 0);
      chk("midmul_rst_c", {31'b0, c_flag}, 0);
      chk("midmul_rst_z", {31'b0, z_flag}, 0);
      chk("midmul_rst_out_valid", {31'b0, out_valid}, 0);
      chk("midmul_rst_in_ready", {31'b0, in_ready}, 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      quiet("midmul_rst_no_out_valid", 12);

      run1(AND_, 8'h0F, 8'hF0, 0, 1, 1, 8'h00, 0, 1);
      run1(SHL,  8'h81, 8'h00, 1, 1, 0, 8'h02, 1, 1);
      run1(ROR,  8'h01, 8'h00, 1, 1, 1, 8'h80, 1, 0);
      run1(RSV,  8'h55, 8'h33, 0, 1, 1, 8'h00, 1, 0);
      run1(SBC,  8'h10, 8'h01, 0, 1, 1, 8'h0E, 0, 0);
      run1(SHR,  8'h81, 8'h00, 1, 1, 1, 8'h40, 1, 0);
      run1(ROL,  8'h81, 8'h00, 1, 1, 1, 8'h03, 1, 0);
      run1(SHL,  8'h81, 8'h00, 0, 1, 1, 8'h81, 0, 0);
      run1(XOR_, 8'hAA, 8'hFF, 0, 1, 1, 8'h55, 0, 0);
      run1(OR_,  8'h00, 8'h00, 0, 1, 1, 8'h00, 0, 1);
      run1(ADD,  8'hFF, 8'h01, 0, 1, 1, 8'h00, 1, 1);
      run1(ADC,  8'h01, 8'h01, 0, 1, 1, 8'h03, 0, 0);
      run1(ROR,  8'h06, 8'h00, 2, 1, 1, 8'h81, 1, 0);
      in_valid = 1'b0;

      for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
      @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
